gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
- Shares a single GCD FSMD unit (controller plus datapath) between N requesters.
- Arbitrates round-robin and latches the winner's operands.
- Pulses the unit's go, waits for the unit's done, and returns the result to the winning requester.
- Resolves zero operands locally, since they would hang the subtractive GCD. Guards the unit with a watchdog that aborts it.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand/result width; must match the GCD datapath.
- TIMEOUT, 1024, max cycles in WAIT before abort; must exceed 2*2^W + 4.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req  in  N  request per requester; held high with stable operands until ack.
- x_in  in  N*W  flattened X operands, requester i at [i*W +: W].
- y_in  in  N*W  flattened Y operands, same packing.
- ack  out  N  one-cycle pulse: operands of requester i captured.
- resp_valid  out  N  one-cycle pulse: result for requester i on resp_d/resp_err.
- resp_d  out  W  result, valid only with a resp_valid bit.
- resp_err  out  1  error flag, valid only with a resp_valid bit.
- gcd_go  out  1  one-cycle start pulse to the GCD controller go_i.
- gcd_x  out  W  X operand to the GCD datapath; stable from ISSUE through WAIT.
- gcd_y  out  W  Y operand to the GCD datapath; stable from ISSUE through WAIT.
- gcd_abort  out  1  one-cycle pulse into the GCD unit's synchronous RESET on timeout.
- gcd_d  in  W  GCD result.
- gcd_done  in  1  one-cycle pulse (registered d_ld); gcd_d valid in that cycle.

Behaviour:
- Reset and outputs:
  - All outputs are registered.
  - RESET forces immediately: state=IDLE, rr_ptr=N-1, owner=0, latches=0, wd_cnt=0, all outputs 0.
- States: IDLE, ISSUE, WAIT, RESP. Only one job is in flight.
- IDLE: if req!=0, pick the winner by round-robin, searching from rr_ptr+1 mod N upward. Then:
  - set owner=winner, rr_ptr=winner;
  - latch x_in/y_in slices;
  - set ack[owner]=1 for the next cycle only.
- From IDLE, next state:
  - both operands 0: RESP with resp_d=0, err=1;
  - exactly one operand 0: RESP with resp_d = the nonzero operand, err=0. No gcd_go.
  - otherwise: ISSUE.
- ISSUE: gcd_go=1 for exactly this cycle; set wd_cnt=0; go to WAIT.
- WAIT:
  - wd_cnt increments every cycle.
  - gcd_done=1: capture gcd_d, set err=0, go to RESP.
  - Otherwise, if wd_cnt==TIMEOUT-1: resp_d=0, err=1, gcd_abort=1 for one cycle, go to RESP.
  - gcd_done and timeout in the same cycle: done wins, no abort.
- RESP: resp_valid[owner]=1 with resp_d/resp_err for one cycle; go to IDLE.
- Latency, non-bypass: ack 1 cycle after req is sampled in IDLE; gcd_go 2 cycles after; resp_valid 1 cycle after gcd_done.
- Latency, bypass: resp_valid 2 cycles after sample.
- Requester contract: req must drop in the cycle after ack is seen. The earliest re-sample is 2+ cycles later, so no double grant occurs.
- Fairness: a requester holding req continuously is granted within N jobs.
- req arriving outside IDLE is ignored until IDLE is reached.
- RESET mid-job: the job is lost, with no resp_valid. The GCD unit is reset by system RESET, not by gcd_abort.
- Widths: wd_cnt is $clog2(TIMEOUT) bits; no other arithmetic.

Decomposition:
- Shared include/package gcd_arb_pkg:
  - state encodings (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11);
  - default W and TIMEOUT.
- One sub-module, rr_picker: combinational N-way round-robin selector.
  - Inputs: req, rr_ptr.
  - Outputs: grant index, any_req.
  - Instantiated once, unit-tested separately.

Test Plan:
- Single request: req[0]=1, x=12, y=18, real GCD unit attached.
  - Expect ack[0] 1 cycle later and a single gcd_go pulse.
  - Expect resp_valid[0] with resp_d=6, err=0, 1 cycle after gcd_done.
- Fairness: all four requesters re-request immediately after each ack, operands (7,21),(9,6),(5,5),(14,35) for requesters 0..3.
  - Expect grant order 0,1,2,3,0.
  - Expect results 7,3,5,7.
- Zero bypass: requester 1 sends x=0, y=9.
  - Expect resp_d=9, err=0 two cycles after sample, no gcd_go.
  - Then x=0, y=0: expect resp_d=0, err=1.
- Watchdog: TIMEOUT=16, stub unit never asserts gcd_done.
  - Expect gcd_abort and err=1, resp_d=0 sixteen cycles after entering WAIT.
  - Then a normal job (x=4, y=6) completes with 2.
- Simultaneous done/timeout: stub asserts gcd_done exactly on wd_cnt==TIMEOUT-1 with gcd_d=5.
  - Expect resp_d=5, err=0, no gcd_abort.
- Async reset: assert RESET mid-WAIT between clock edges.
  - Expect all outputs 0 before the next edge and no resp_valid.
  - After release, req[2] with x=8, y=12 is granted first and returns 4.

Source files
------------

// File: rtl/gcd_arb_pkg.sv
// rtl/gcd_arb_pkg.sv - shared definitions for the GCD arbiter
//
// Purpose: FSM state encoding and default parameter values used by
// gcd_arbiter and its round-robin picker.
// Ports: none (package).

package gcd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam int DEFAULT_N       = 4;
  localparam int DEFAULT_W       = 8;
  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational N-way round-robin selector
//
// Purpose: picks the first asserted request searching upward from
// rr_ptr+1 (mod N), so the last winner has the lowest priority.
// Ports:
//   req      in  N   request vector
//   rr_ptr   in  IW  index of the previous winner
//   grant    out IW  index of the selected requester (0 when none)
//   any_req  out 1   at least one request is asserted

module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  int            idx;
  logic [IW-1:0] idx_t;
  logic          found;

  always_comb begin
    grant   = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    idx_t   = '0;
    // k runs 1..N so rr_ptr itself is visited last.
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(rr_ptr) + k) % N;
      idx_t = IW'(idx);
      if (!found && req[idx_t]) begin
        grant = idx_t;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin sharing of one GCD FSMD unit among N requesters
//
// Purpose: grants one requester at a time, latches its operands, starts the
// shared GCD unit, waits for its result under a watchdog and returns the
// result to the winner. Zero operands are answered locally because the
// subtractive GCD would never terminate on them.
// Ports:
//   CLK         in  1    clock, rising edge
//   RESET       in  1    asynchronous active-high reset
//   req         in  N    per-requester request, held until ack
//   x_in, y_in  in  N*W  flattened operands, requester i at [i*W +: W]
//   ack         out N    one-cycle pulse: operands of requester i captured
//   resp_valid  out N    one-cycle pulse: result for requester i present
//   resp_d      out W    result
//   resp_err    out 1    error flag (zero/zero operands or watchdog abort)
//   gcd_go      out 1    start pulse to the GCD controller
//   gcd_x/gcd_y out W    operands to the GCD datapath
//   gcd_abort   out 1    pulse into the GCD unit's synchronous reset
//   gcd_d       in  W    GCD result
//   gcd_done    in  1    GCD result valid pulse

module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int W       = DEFAULT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] x_in,
  input  logic [N*W-1:0] y_in,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   resp_valid,
  output logic [W-1:0]   resp_d,
  output logic           resp_err,
  output logic           gcd_go,
  output logic [W-1:0]   gcd_x,
  output logic [W-1:0]   gcd_y,
  output logic           gcd_abort,
  input  logic [W-1:0]   gcd_d,
  input  logic           gcd_done
);

  localparam int IW  = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT);

  state_e         state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [N-1:0]   resp_valid_q, resp_valid_d;
  logic [W-1:0]   resp_d_q, resp_d_d;
  logic           resp_err_q, resp_err_d;
  logic           gcd_go_q, gcd_go_d;
  logic           gcd_abort_q, gcd_abort_d;
  logic           byp_q, byp_d;

  logic [IW-1:0]  grant;
  logic           any_req;
  logic [W-1:0]   x_sel, y_sel;

  rr_picker #(.N(N), .IW(IW)) u_rr_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .grant   (grant),
    .any_req (any_req)
  );

  assign x_sel = x_in[int'(grant)*W +: W];
  assign y_sel = y_in[int'(grant)*W +: W];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    x_d          = x_q;
    y_d          = y_q;
    wd_cnt_d     = wd_cnt_q;
    resp_d_d     = resp_d_q;
    resp_err_d   = resp_err_q;
    byp_d        = byp_q;
    ack_d        = '0;
    resp_valid_d = '0;
    gcd_go_d     = 1'b0;
    gcd_abort_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d  = grant;
          rr_ptr_d = grant;
          x_d      = x_sel;
          y_d      = y_sel;
          ack_d    = N'(1) << grant;
          if (x_sel == '0 && y_sel == '0) begin
            resp_d_d   = '0;
            resp_err_d = 1'b1;
            byp_d      = 1'b1;
            state_d    = ST_RESP;
          end else if (x_sel == '0) begin
            resp_d_d   = y_sel;
            resp_err_d = 1'b0;
            byp_d      = 1'b1;
            state_d    = ST_RESP;
          end else if (y_sel == '0) begin
            resp_d_d   = x_sel;
            resp_err_d = 1'b0;
            byp_d      = 1'b1;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        gcd_go_d = 1'b1;
        wd_cnt_d = '0;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        wd_cnt_d = wd_cnt_q + WDW'(1);
        // Done is checked first so a result landing on the last watchdog
        // cycle is delivered rather than aborted.
        if (gcd_done) begin
          resp_d_d     = gcd_d;
          resp_err_d   = 1'b0;
          resp_valid_d = N'(1) << owner_q;
          byp_d        = 1'b0;
          state_d      = ST_RESP;
        end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
          resp_d_d     = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = N'(1) << owner_q;
          gcd_abort_d  = 1'b1;
          byp_d        = 1'b0;
          state_d      = ST_RESP;
        end
      end

      ST_RESP: begin
        // Unit results were already flagged on the way out of WAIT; locally
        // resolved jobs are answered here, on the second cycle after sampling.
        if (byp_q) begin
          resp_valid_d = N'(1) << owner_q;
        end
        byp_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= IW'(N - 1);
      owner_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      wd_cnt_q     <= '0;
      ack_q        <= '0;
      resp_valid_q <= '0;
      resp_d_q     <= '0;
      resp_err_q   <= 1'b0;
      gcd_go_q     <= 1'b0;
      gcd_abort_q  <= 1'b0;
      byp_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wd_cnt_q     <= wd_cnt_d;
      ack_q        <= ack_d;
      resp_valid_q <= resp_valid_d;
      resp_d_q     <= resp_d_d;
      resp_err_q   <= resp_err_d;
      gcd_go_q     <= gcd_go_d;
      gcd_abort_q  <= gcd_abort_d;
      byp_q        <= byp_d;
    end
  end

  assign ack        = ack_q;
  assign resp_valid = resp_valid_q;
  assign resp_d     = resp_d_q;
  assign resp_err   = resp_err_q;
  assign gcd_go     = gcd_go_q;
  assign gcd_x      = x_q;
  assign gcd_y      = y_q;
  assign gcd_abort  = gcd_abort_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - directed self-checking bench for gcd_arbiter

module tb_gcd_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] x_in = '0;
  logic [N*W-1:0] y_in = '0;
  logic [N-1:0]   ack, resp_valid;
  logic [W-1:0]   resp_d, gcd_x, gcd_y;
  logic           resp_err, gcd_go, gcd_abort;
  logic [W-1:0]   gcd_d;
  logic           gcd_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int gcd_mode  = 0;  // 0: real subtractive GCD, 1: never done, 2: done after fixed latency with 5

  gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req        (req),
    .x_in       (x_in),
    .y_in       (y_in),
    .ack        (ack),
    .resp_valid (resp_valid),
    .resp_d     (resp_d),
    .resp_err   (resp_err),
    .gcd_go     (gcd_go),
    .gcd_x      (gcd_x),
    .gcd_y      (gcd_y),
    .gcd_abort  (gcd_abort),
    .gcd_d      (gcd_d),
    .gcd_done   (gcd_done)
  );

  always #5 CLK = ~CLK;

  // GCD unit model: go sampled, then one subtract step per cycle; done is a
  // registered one-cycle pulse.
  logic [W-1:0] m_a, m_b;
  logic         m_busy;
  int           m_cnt;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_a <= '0; m_b <= '0; m_busy <= 1'b0; m_cnt <= 0;
      gcd_done <= 1'b0; gcd_d <= '0;
    end else begin
      gcd_done <= 1'b0;
      if (gcd_abort) begin
        m_busy <= 1'b0;
      end else if (gcd_go) begin
        m_a <= gcd_x; m_b <= gcd_y; m_cnt <= 0; m_busy <= 1'b1;
      end else if (m_busy) begin
        if (gcd_mode == 0) begin
          if (m_a == m_b) begin
            gcd_done <= 1'b1; gcd_d <= m_a; m_busy <= 1'b0;
          end else if (m_a > m_b) begin
            m_a <= m_a - m_b;
          end else begin
            m_b <= m_b - m_a;
          end
        end else if (gcd_mode == 2) begin
          // Lands on the cycle where the watchdog count reaches TO-1.
          if (m_cnt == 13) begin
            gcd_done <= 1'b1; gcd_d <= 8'd5; m_busy <= 1'b0;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    x_in[i*W +: W] = x;
    y_in[i*W +: W] = y;
  endtask

  task automatic wait_resp(input string tag, input int max);
    int n = 0;
    while (resp_valid == '0 && n < max) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_seen"}, 64'(resp_valid != '0), 1);
  endtask

  task automatic run_job(input string tag, input int i, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] ed, input logic ee);
    set_op(i, x, y);
    req[i] = 1'b1;
    @(negedge CLK);
    chk({tag, "_ack"}, 64'(ack), 64'(1) << i);
    req[i] = 1'b0;
    wait_resp(tag, 64);
    chk({tag, "_rv"}, 64'(resp_valid), 64'(1) << i);
    chk({tag, "_d"}, 64'(resp_d), 64'(ed));
    chk({tag, "_err"}, 64'(resp_err), 64'(ee));
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset_outs", 64'({ack, resp_valid, resp_d, resp_err, gcd_go, gcd_x, gcd_y, gcd_abort}), 0);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int n;
    int go_cnt;
    logic seen;
    int ord[5] = '{0, 1, 2, 3, 0};
    int xs[4]  = '{7, 9, 5, 14};
    int ys[4]  = '{21, 6, 5, 35};
    int res[4] = '{7, 3, 5, 7};

    do_reset();

    // Single request with latency checks.
    set_op(0, 12, 18);
    req = 4'b0001;
    @(negedge CLK);
    chk("t1_ack", 64'(ack), 1);
    chk("t1_go_early", 64'(gcd_go), 0);
    req = '0;
    @(negedge CLK);
    chk("t1_go", 64'(gcd_go), 1);
    chk("t1_x", 64'(gcd_x), 12);
    chk("t1_y", 64'(gcd_y), 18);
    go_cnt = 1;
    n = 0;
    while (!gcd_done && n < 64) begin
      @(negedge CLK);
      if (gcd_go) go_cnt++;
      n++;
    end
    chk("t1_done_seen", 64'(gcd_done), 1);
    @(negedge CLK);
    chk("t1_rv", 64'(resp_valid), 1);
    chk("t1_d", 64'(resp_d), 6);
    chk("t1_err", 64'(resp_err), 0);
    chk("t1_go_count", 64'(go_cnt), 1);
    @(negedge CLK);
    chk("t1_rv_pulse", 64'(resp_valid), 0);

    // Fairness from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, W'(xs[i]), W'(ys[i]));
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (ack == '0 && n < 64) begin
        @(negedge CLK);
        n++;
      end
      chk("fair_grant", 64'(ack), 64'(1) << ord[j]);
      req[ord[j]] = 1'b0;
      @(negedge CLK);
      req[ord[j]] = 1'b1;
      wait_resp("fair", 64);
      chk("fair_rv", 64'(resp_valid), 64'(1) << ord[j]);
      chk("fair_d", 64'(resp_d), 64'(res[ord[j]]));
      chk("fair_err", 64'(resp_err), 0);
      if (j == 4) req = '0;
    end
    repeat (2) @(negedge CLK);

    // Zero-operand bypass: two cycles after sample, no go.
    set_op(1, 0, 9);
    req = 4'b0010;
    @(negedge CLK);
    chk("byp_ack", 64'(ack), 2);
    chk("byp_go0", 64'(gcd_go), 0);
    req = '0;
    @(negedge CLK);
    chk("byp_rv", 64'(resp_valid), 2);
    chk("byp_d", 64'(resp_d), 9);
    chk("byp_err", 64'(resp_err), 0);
    chk("byp_go1", 64'(gcd_go), 0);
    @(negedge CLK);
    chk("byp_rv_pulse", 64'(resp_valid), 0);
    chk("byp_go2", 64'(gcd_go), 0);
    set_op(1, 0, 0);
    req = 4'b0010;
    @(negedge CLK);
    req = '0;
    @(negedge CLK);
    chk("byp00_rv", 64'(resp_valid), 2);
    chk("byp00_d", 64'(resp_d), 0);
    chk("byp00_err", 64'(resp_err), 1);
    @(negedge CLK);
    run_job("byp_x5", 3, 5, 0, 5, 0);

    // Watchdog abort exactly TO cycles after entering WAIT.
    gcd_mode = 1;
    set_op(3, 10, 15);
    req = 4'b1000;
    @(negedge CLK);
    chk("wd_ack", 64'(ack), 8);
    req = '0;
    @(negedge CLK);
    chk("wd_go", 64'(gcd_go), 1);
    seen = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge CLK);
      seen = seen | gcd_abort | (resp_valid != '0);
    end
    chk("wd_early", 64'(seen), 0);
    @(negedge CLK);
    chk("wd_abort", 64'(gcd_abort), 1);
    chk("wd_rv", 64'(resp_valid), 8);
    chk("wd_d", 64'(resp_d), 0);
    chk("wd_err", 64'(resp_err), 1);
    @(negedge CLK);
    chk("wd_abort_pulse", 64'(gcd_abort), 0);
    gcd_mode = 0;
    @(negedge CLK);
    run_job("wd_after", 0, 4, 6, 2, 0);

    // Done on the last watchdog cycle wins.
    gcd_mode = 2;
    set_op(2, 10, 20);
    req = 4'b0100;
    @(negedge CLK);
    req = '0;
    @(negedge CLK);
    chk("sim_go", 64'(gcd_go), 1);
    seen = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge CLK);
      seen = seen | gcd_abort | (resp_valid != '0);
    end
    chk("sim_early", 64'(seen), 0);
    @(negedge CLK);
    chk("sim_abort", 64'(gcd_abort), 0);
    chk("sim_rv", 64'(resp_valid), 4);
    chk("sim_d", 64'(resp_d), 5);
    chk("sim_err", 64'(resp_err), 0);
    @(negedge CLK);

    // Asynchronous reset mid-WAIT.
    gcd_mode = 1;
    set_op(1, 3, 9);
    req = 4'b0010;
    @(negedge CLK);
    req = '0;
    repeat (4) @(negedge CLK);
    chk("ar_pre_x", 64'(gcd_x), 3);
    #2;
    RESET = 1'b1;
    #1;
    chk("ar_outs", 64'({ack, resp_valid, resp_d, resp_err, gcd_go, gcd_x, gcd_y, gcd_abort}), 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      seen = seen | (resp_valid != '0);
    end
    RESET = 1'b0;
    gcd_mode = 0;
    repeat (2) begin
      @(negedge CLK);
      seen = seen | (resp_valid != '0);
    end
    chk("ar_no_rv", 64'(seen), 0);
    run_job("ar_after", 2, 8, 12, 4, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
